// File: rtl/tmr_scrub_ctrl.sv
// Round-robin scrub scheduler for a bank of triplicated registers: strobes one
// entry every PERIOD+1 cycles, defers around functional writes, counts voter mismatches.
module tmr_scrub_ctrl #(
    parameter int N        = 4,
    parameter int PERIOD   = 16,
    parameter int CW       = 8,
    parameter int MAXDEFER = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  wr_busy,
    input  logic [N-1:0]  mismatch,
    input  logic          clr_err,
    output logic [N-1:0]  scrub_we,
    output logic [IW-1:0] scrub_idx,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic          skip_flag,
    output logic          pass_done,
    output logic [1:0]    state_dbg
);

    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DW = $clog2(MAXDEFER + 1);

    localparam logic [TW-1:0] TIMER_LOAD = TW'(PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N - 1);
    localparam logic [DW-1:0] DEFER_MAX  = DW'(MAXDEFER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SCRUB = 2'd2
    } state_t;

    // Handshake: scrub_we[i] is a single-cycle enable; the protected entry
    // samples it on the same edge, there is no ready back-pressure. wr_busy is
    // the only hold-off and merely delays the strobe.

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [IW-1:0] idx, idx_n;
    logic [DW-1:0] defer, defer_n;
    logic          strobe;
    logic          skip;
    logic          advance;
    logic          counted;
    logic          err_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= TIMER_LOAD;
            idx   <= '0;
            defer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            defer <= defer_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        defer_n = defer;
        strobe  = 1'b0;
        skip    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = WAIT;
                    timer_n = TIMER_LOAD;
                end
            end
            WAIT: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (timer == '0) begin
                    state_n = SCRUB;
                    defer_n = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            SCRUB: begin
                // rst is gated here so the reset cycle itself never strobes
                if (!en || rst) begin
                    state_n = IDLE;
                end else if (!wr_busy[idx]) begin
                    strobe = 1'b1;
                end else if (defer == DEFER_MAX) begin
                    skip = 1'b1;
                end else begin
                    defer_n = defer + 1'b1;
                end
                if (strobe || skip) begin
                    state_n = WAIT;
                    timer_n = TIMER_LOAD;
                    idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign advance = strobe | skip;
    assign counted = strobe & mismatch[idx];
    assign err_sat = &err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            skip_flag <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            // A mismatch landing with clr_err survives the clear as count 1
            if (clr_err) begin
                err_cnt <= counted ? CW'(1) : '0;
            end else if (counted && !err_sat) begin
                err_cnt <= err_cnt + 1'b1;
            end
            err_flag  <= (err_flag & ~clr_err) | counted;
            skip_flag <= (skip_flag & ~clr_err) | skip;
            pass_done <= advance && (idx == LAST_IDX);
        end
    end

    assign scrub_we  = strobe ? (N'(1) << idx) : '0;
    assign scrub_idx = idx;
    assign state_dbg = state;

    a_we_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(scrub_we));
    a_we_scrub  : assert property (@(posedge clk) disable iff (rst)
                                   (scrub_we != '0) |-> (state == SCRUB));

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Directed bench for tmr_scrub_ctrl with N=4, PERIOD=4, CW=2, MAXDEFER=8.
// Cycle k is the cycle after the k-th edge following en=1 in IDLE (edge 0 samples en).
module tb_tmr_scrub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] wr_busy;
    logic [3:0] mismatch;
    logic       clr_err;
    logic [3:0] scrub_we;
    logic [1:0] scrub_idx;
    logic [1:0] err_cnt;
    logic       err_flag;
    logic       skip_flag;
    logic       pass_done;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    tmr_scrub_ctrl #(.N(4), .PERIOD(4), .CW(2), .MAXDEFER(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr_busy   (wr_busy),
        .mismatch  (mismatch),
        .clr_err   (clr_err),
        .scrub_we  (scrub_we),
        .scrub_idx (scrub_idx),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .skip_flag (skip_flag),
        .pass_done (pass_done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        wr_busy  = '0;
        mismatch = '0;
        clr_err  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        step();
        #1;
        n_vec++;
        if ({scrub_we, scrub_idx, err_cnt, err_flag, skip_flag, pass_done, state_dbg} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_vals got we=%b idx=%0d cnt=%0d ef=%b sf=%b pd=%b st=%0d want all 0",
                     scrub_we, scrub_idx, err_cnt, err_flag, skip_flag, pass_done, state_dbg);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_we;
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            step();
            #1;
            case (k)
                4, 24:   exp_we = 4'b0001;
                9:       exp_we = 4'b0010;
                14:      exp_we = 4'b0100;
                19:      exp_we = 4'b1000;
                default: exp_we = 4'b0000;
            endcase
            n_vec++;
            if (scrub_we !== exp_we) begin
                n_err++;
                $display("FAIL rr_we k=%0d got %b want %b", k, scrub_we, exp_we);
            end
            n_vec++;
            if (pass_done !== (k == 20)) begin
                n_err++;
                $display("FAIL rr_pass_done k=%0d got %b want %b", k, pass_done, k == 20);
            end
        end
        n_vec++;
        if (err_cnt !== 2'd0 || scrub_idx !== 2'd0) begin
            n_err++;
            $display("FAIL rr_end got cnt=%0d idx=%0d want cnt=0 idx=0", err_cnt, scrub_idx);
        end
    endtask

    task automatic test_defer();
        logic [3:0] exp_we;
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            step();
            wr_busy  = (k >= 9 && k <= 11) ? 4'b0010 : 4'b0000;
            mismatch = (k >= 9 && k <= 11) ? 4'b0010 : 4'b0000;
            #1;
            case (k)
                4:       exp_we = 4'b0001;
                12:      exp_we = 4'b0010;
                17:      exp_we = 4'b0100;
                default: exp_we = 4'b0000;
            endcase
            n_vec++;
            if (scrub_we !== exp_we) begin
                n_err++;
                $display("FAIL defer_we k=%0d got %b want %b", k, scrub_we, exp_we);
            end
            if (k == 10) begin
                n_vec++;
                if (scrub_idx !== 2'd1 || state_dbg !== 2'd2) begin
                    n_err++;
                    $display("FAIL defer_hold got idx=%0d st=%0d want idx=1 st=2", scrub_idx, state_dbg);
                end
            end
        end
        n_vec++;
        if (skip_flag !== 1'b0 || err_cnt !== 2'd0) begin
            n_err++;
            $display("FAIL defer_flags got sf=%b cnt=%0d want sf=0 cnt=0", skip_flag, err_cnt);
        end
        wr_busy  = '0;
        mismatch = '0;
    endtask

    task automatic test_skip();
        logic [3:0] exp_we;
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            step();
            wr_busy = (k >= 14 && k <= 33) ? 4'b0100 : 4'b0000;
            #1;
            case (k)
                4, 32:   exp_we = 4'b0001;
                9:       exp_we = 4'b0010;
                27:      exp_we = 4'b1000;
                default: exp_we = 4'b0000;
            endcase
            n_vec++;
            if (scrub_we !== exp_we) begin
                n_err++;
                $display("FAIL skip_we k=%0d got %b want %b", k, scrub_we, exp_we);
            end
            if (k == 22) begin
                n_vec++;
                if (skip_flag !== 1'b0 || scrub_idx !== 2'd2) begin
                    n_err++;
                    $display("FAIL skip_before got sf=%b idx=%0d want sf=0 idx=2", skip_flag, scrub_idx);
                end
            end
            if (k == 23) begin
                n_vec++;
                if (skip_flag !== 1'b1 || scrub_idx !== 2'd3) begin
                    n_err++;
                    $display("FAIL skip_after got sf=%b idx=%0d want sf=1 idx=3", skip_flag, scrub_idx);
                end
            end
            if (k == 28) begin
                n_vec++;
                if (pass_done !== 1'b1) begin
                    n_err++;
                    $display("FAIL skip_pass_done got %b want 1", pass_done);
                end
            end
        end
        wr_busy = '0;
    endtask

    task automatic test_errors();
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            step();
            mismatch = (k >= 3) ? 4'b1111 : 4'b0000;
            #1;
            if (k == 4) begin
                n_vec++;
                if (err_cnt !== 2'd0 || err_flag !== 1'b0) begin
                    n_err++;
                    $display("FAIL err_off_strobe got cnt=%0d ef=%b want 0 0", err_cnt, err_flag);
                end
            end
            if (k == 5) begin
                n_vec++;
                if (err_cnt !== 2'd1 || err_flag !== 1'b1) begin
                    n_err++;
                    $display("FAIL err_first got cnt=%0d ef=%b want 1 1", err_cnt, err_flag);
                end
            end
            if (k == 8) begin
                n_vec++;
                if (err_cnt !== 2'd1) begin
                    n_err++;
                    $display("FAIL err_wait_ignored got cnt=%0d want 1", err_cnt);
                end
            end
            if (k == 10) begin
                n_vec++;
                if (err_cnt !== 2'd2) begin
                    n_err++;
                    $display("FAIL err_second got cnt=%0d want 2", err_cnt);
                end
            end
            if (k == 15 || k == 25) begin
                n_vec++;
                if (err_cnt !== 2'd3) begin
                    n_err++;
                    $display("FAIL err_sat k=%0d got cnt=%0d want 3", k, err_cnt);
                end
            end
        end
        mismatch = '0;
    endtask

    task automatic test_clr();
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            step();
            wr_busy  = (k >= 4 && k <= 12) ? 4'b0001 : 4'b0000;
            clr_err  = (k == 12 || k == 15 || k == 22 || k == 24);
            mismatch = (k == 17) ? 4'b0010 : (k == 22) ? 4'b0100 : 4'b0000;
            #1;
            if (k == 12) begin
                n_vec++;
                if (scrub_we !== 4'b0000) begin
                    n_err++;
                    $display("FAIL clr_skip_we got %b want 0000", scrub_we);
                end
            end
            if (k == 13) begin
                n_vec++;
                if (skip_flag !== 1'b1 || scrub_idx !== 2'd1) begin
                    n_err++;
                    $display("FAIL clr_with_skip got sf=%b idx=%0d want sf=1 idx=1", skip_flag, scrub_idx);
                end
            end
            if (k == 16) begin
                n_vec++;
                if (skip_flag !== 1'b0) begin
                    n_err++;
                    $display("FAIL clr_skip_flag got %b want 0", skip_flag);
                end
            end
            if (k == 17) begin
                n_vec++;
                if (scrub_we !== 4'b0010) begin
                    n_err++;
                    $display("FAIL clr_we1 got %b want 0010", scrub_we);
                end
            end
            if (k == 18) begin
                n_vec++;
                if (err_cnt !== 2'd1 || err_flag !== 1'b1) begin
                    n_err++;
                    $display("FAIL clr_count got cnt=%0d ef=%b want 1 1", err_cnt, err_flag);
                end
            end
            if (k == 23) begin
                n_vec++;
                if (err_cnt !== 2'd1 || err_flag !== 1'b1) begin
                    n_err++;
                    $display("FAIL clr_with_mismatch got cnt=%0d ef=%b want 1 1", err_cnt, err_flag);
                end
            end
            if (k == 25) begin
                n_vec++;
                if (err_cnt !== 2'd0 || err_flag !== 1'b0 || skip_flag !== 1'b0) begin
                    n_err++;
                    $display("FAIL clr_alone got cnt=%0d ef=%b sf=%b want 0 0 0", err_cnt, err_flag, skip_flag);
                end
            end
        end
        wr_busy  = '0;
        clr_err  = 1'b0;
        mismatch = '0;
    endtask

    task automatic test_en_drop();
        logic [3:0] exp_we;
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            step();
            en = !(k >= 11 && k <= 15);
            #1;
            case (k)
                4:       exp_we = 4'b0001;
                9:       exp_we = 4'b0010;
                21:      exp_we = 4'b0100;
                default: exp_we = 4'b0000;
            endcase
            n_vec++;
            if (scrub_we !== exp_we) begin
                n_err++;
                $display("FAIL en_drop_we k=%0d got %b want %b", k, scrub_we, exp_we);
            end
            if (k == 12) begin
                n_vec++;
                if (state_dbg !== 2'd0 || scrub_idx !== 2'd2) begin
                    n_err++;
                    $display("FAIL en_drop_idle got st=%0d idx=%0d want st=0 idx=2", state_dbg, scrub_idx);
                end
            end
        end
    endtask

    task automatic test_rst_defer();
        logic [3:0] exp_we;
        do_reset();
        en = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            step();
            mismatch = (k == 4) ? 4'b0001 : 4'b0000;
            wr_busy  = (k >= 9 && k <= 10) ? 4'b0010 : 4'b0000;
            rst      = (k == 11);
            #1;
            case (k)
                4, 17:   exp_we = 4'b0001;
                default: exp_we = 4'b0000;
            endcase
            n_vec++;
            if (scrub_we !== exp_we) begin
                n_err++;
                $display("FAIL rst_we k=%0d got %b want %b", k, scrub_we, exp_we);
            end
            if (k == 10) begin
                n_vec++;
                if (err_cnt !== 2'd1 || state_dbg !== 2'd2) begin
                    n_err++;
                    $display("FAIL rst_pre got cnt=%0d st=%0d want cnt=1 st=2", err_cnt, state_dbg);
                end
            end
            if (k == 12) begin
                n_vec++;
                if ({scrub_idx, err_cnt, err_flag, skip_flag, pass_done, state_dbg} !== 9'd0) begin
                    n_err++;
                    $display("FAIL rst_mid got idx=%0d cnt=%0d ef=%b sf=%b pd=%b st=%0d want all 0",
                             scrub_idx, err_cnt, err_flag, skip_flag, pass_done, state_dbg);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_defer();
        test_skip();
        test_errors();
        test_clr();
        test_en_drop();
        test_rst_defer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
